// File: rtl/video_mem_sched.sv
// Frame-buffer port scheduler: display reads during the active region, streamed pixel
// writes into a separate bank during blanking, bank swap at vertical blank.
module video_mem_sched #(
    parameter int WIDTH       = 200,
    parameter int HEIGHT      = 150,
    parameter int SCALE_SHIFT = 2,
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int WHOLE_LINE  = 1056,
    parameter int WHOLE_FRAME = 628,
    parameter int NUM_BANKS   = 16,
    parameter int READ_LAT    = 3,
    parameter int X_ADDRW     = $clog2(WIDTH),
    parameter int Y_ADDRW     = $clog2(HEIGHT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [10:0]        h_count,
    input  logic [9:0]         v_count,
    input  logic               in_valid,
    input  logic               in_data,
    output logic               in_ready,
    output logic [3:0]         bank_counter,
    output logic [X_ADDRW-1:0] x_pos,
    output logic [Y_ADDRW-1:0] y_pos,
    output logic               data_in,
    output logic               we,
    output logic               pixel_active,
    output logic               frame_swap,
    output logic [3:0]         display_bank
);

    localparam logic [10:0]        H_ACT     = 11'(H_ACTIVE);
    localparam logic [10:0]        H_GUARD   = 11'(H_ACTIVE + READ_LAT);
    localparam logic [10:0]        H_LAST    = 11'(WHOLE_LINE - 1);
    localparam logic [9:0]         V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0]         V_PRE     = 10'(V_ACTIVE - 1);
    localparam logic [9:0]         V_LAST    = 10'(WHOLE_FRAME - 1);
    localparam logic [X_ADDRW-1:0] X_LAST    = X_ADDRW'(WIDTH - 1);
    localparam logic [Y_ADDRW-1:0] Y_LAST    = Y_ADDRW'(HEIGHT - 1);
    localparam logic [3:0]         BANK_LAST = 4'(NUM_BANKS - 1);

    logic               active;
    logic               read_guard;
    logic               pre_line;
    logic               write_window;
    logic               swap_cycle;
    logic               accept;
    logic [3:0]         write_bank;
    logic [X_ADDRW-1:0] wx;
    logic [Y_ADDRW-1:0] wy;
    logic               frame_full;
    logic [READ_LAT-1:0] act_pipe;

    assign active     = (h_count < H_ACT) && (v_count < V_ACT);
    // Reads still in flight for READ_LAT clocks after the visible line ends.
    assign read_guard = (h_count < H_GUARD) && (v_count < V_ACT);
    // Last clock before a visible line: the read address must already be driven.
    assign pre_line   = (h_count == H_LAST) && ((v_count < V_PRE) || (v_count == V_LAST));

    assign write_window = !read_guard && !pre_line;
    assign swap_cycle   = (v_count == V_ACT) && (h_count == 11'd0);
    assign in_ready     = write_window && !frame_full && !swap_cycle && !reset;
    assign accept       = in_valid && in_ready;
    assign pixel_active = act_pipe[READ_LAT-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            display_bank <= 4'd0;
            write_bank   <= 4'd1;
            wx           <= '0;
            wy           <= '0;
            frame_full   <= 1'b0;
            bank_counter <= 4'd0;
            x_pos        <= '0;
            y_pos        <= '0;
            data_in      <= 1'b0;
            we           <= 1'b0;
            frame_swap   <= 1'b0;
            act_pipe     <= '0;
        end else begin
            act_pipe   <= (act_pipe << 1) | READ_LAT'(active);
            frame_swap <= swap_cycle && frame_full;

            if (active) begin
                x_pos        <= X_ADDRW'(h_count >> SCALE_SHIFT);
                y_pos        <= Y_ADDRW'(v_count >> SCALE_SHIFT);
                bank_counter <= display_bank;
                we           <= 1'b0;
            end else if (accept) begin
                we           <= 1'b1;
                data_in      <= in_data;
                x_pos        <= wx;
                y_pos        <= wy;
                bank_counter <= write_bank;
                if (wx == X_LAST) begin
                    wx <= '0;
                    if (wy == Y_LAST) begin
                        wy         <= '0;
                        frame_full <= 1'b1;
                    end else begin
                        wy <= wy + 1'b1;
                    end
                end else begin
                    wx <= wx + 1'b1;
                end
            end else begin
                we           <= 1'b0;
                bank_counter <= write_bank;
            end

            // accept excludes both swap_cycle and frame_full, so this never collides.
            if (swap_cycle && frame_full) begin
                display_bank <= write_bank;
                write_bank   <= (write_bank == BANK_LAST) ? 4'd0 : write_bank + 4'd1;
                frame_full   <= 1'b0;
            end
        end
    end

endmodule
